way_probe_ctrl: RTL

Sequencer that performs one set-associative tag lookup per request, probing the way predictor's guess first and then the remaining ways serially through a single-way tag-array read port. It sits between the L1 request front-end and the tag array, drives the way predictor's index and update ports, and exports saturating lookup/prediction-accuracy counters for the timing-instrumentation path.

---
 rtl/way_probe_ctrl.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/way_probe_ctrl.sv
// way_probe_ctrl
// Runs one set-associative tag lookup per request. The way predictor's guess
// is probed first, then the remaining ways are probed in ascending order
// (skipping the guessed way) through a single-way tag-array read port.
// A hit found after the first probe trains the predictor. Saturating
// counters track completed lookups and first-probe hits.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid/ready/index/tag  lookup request (ready only in IDLE)
//   pred_index, pred_way       predictor read (pred_way is combinational)
//   pred_update_en/actual_way  predictor write strobe and trained way
//   tag_rd_en/index/way        tag-array read request
//   tag_rd_tag, tag_rd_vld     tag-array read data, one cycle after tag_rd_en
//   resp_*                     lookup result, held until resp_ready
//   stat_clr                   synchronous clear of the statistics counters
//   stat_lookups/pred_hits     saturating statistics counters
module way_probe_ctrl #(
  parameter int NUM_SETS   = 64,
  parameter int NUM_WAYS   = 4,
  parameter int TAG_BITS   = 20,
  parameter int INDEX_BITS = $clog2(NUM_SETS),
  parameter int WAY_BITS   = $clog2(NUM_WAYS),
  parameter int CNT_BITS   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [INDEX_BITS-1:0] req_index,
  input  logic [TAG_BITS-1:0]   req_tag,
  output logic [INDEX_BITS-1:0] pred_index,
  input  logic [WAY_BITS-1:0]   pred_way,
  output logic                  pred_update_en,
  output logic [WAY_BITS-1:0]   pred_actual_way,
  output logic                  tag_rd_en,
  output logic [INDEX_BITS-1:0] tag_rd_index,
  output logic [WAY_BITS-1:0]   tag_rd_way,
  input  logic [TAG_BITS-1:0]   tag_rd_tag,
  input  logic                  tag_rd_vld,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic                  resp_hit,
  output logic [WAY_BITS-1:0]   resp_way,
  output logic                  resp_pred_hit,
  output logic [WAY_BITS:0]     resp_probes,
  input  logic                  stat_clr,
  output logic [CNT_BITS-1:0]   stat_lookups,
  output logic [CNT_BITS-1:0]   stat_pred_hits
);

  typedef enum logic [1:0] {IDLE, PROBE, CHECK, RESP} state_t;

  localparam logic [WAY_BITS:0]   MAX_PROBES = (WAY_BITS+1)'(NUM_WAYS);
  localparam logic [WAY_BITS:0]   ONE_PROBE  = (WAY_BITS+1)'(1);
  localparam logic [CNT_BITS-1:0] CNT_MAX    = '1;

  state_t                state_q, state_nxt;
  logic [INDEX_BITS-1:0] index_q;
  logic [TAG_BITS-1:0]   tag_q;
  logic [WAY_BITS-1:0]   first_way_q;
  logic [WAY_BITS-1:0]   cur_way_q;
  logic [WAY_BITS:0]     probes_q;
  logic                  hit_q;
  logic [WAY_BITS-1:0]   way_q;
  logic                  pred_hit_q;
  logic [CNT_BITS-1:0]   lookups_q;
  logic [CNT_BITS-1:0]   pred_hits_q;
  logic                  match;
  logic [WAY_BITS-1:0]   way_step;
  logic                  handshake;

  assign match     = tag_rd_vld && (tag_rd_tag == tag_q);
  assign handshake = (state_q == RESP) && resp_ready;

  // Next way in probe order: after the predicted way restart at 0, then
  // climb, hopping over the predicted way. The walk ends after NUM_WAYS
  // probes, so the wrap past the top way is never used.
  always_comb begin
    way_step = (cur_way_q == first_way_q) ? '0 : cur_way_q + WAY_BITS'(1);
    if (way_step == first_way_q) begin
      way_step = way_step + WAY_BITS'(1);
    end
  end

  always_comb begin
    state_nxt      = state_q;
    req_ready      = 1'b0;
    tag_rd_en      = 1'b0;
    pred_update_en = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = PROBE;
      end
      PROBE: begin
        tag_rd_en = 1'b1;
        state_nxt = CHECK;
      end
      CHECK: begin
        if (match) begin
          // Only a hit the predictor missed needs training.
          pred_update_en = (probes_q != ONE_PROBE);
          state_nxt      = RESP;
        end else if (probes_q == MAX_PROBES) begin
          state_nxt = RESP;
        end else begin
          state_nxt = PROBE;
        end
      end
      RESP: begin
        if (resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      index_q     <= '0;
      tag_q       <= '0;
      first_way_q <= '0;
      cur_way_q   <= '0;
      probes_q    <= '0;
      hit_q       <= 1'b0;
      way_q       <= '0;
      pred_hit_q  <= 1'b0;
    end else begin
      state_q <= state_nxt;
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            index_q     <= req_index;
            tag_q       <= req_tag;
            first_way_q <= pred_way;
            cur_way_q   <= pred_way;
            probes_q    <= '0;
            hit_q       <= 1'b0;
            way_q       <= '0;
            pred_hit_q  <= 1'b0;
          end
        end
        PROBE: probes_q <= probes_q + ONE_PROBE;
        CHECK: begin
          if (match) begin
            hit_q      <= 1'b1;
            way_q      <= cur_way_q;
            pred_hit_q <= (probes_q == ONE_PROBE);
          end else if (probes_q != MAX_PROBES) begin
            cur_way_q <= way_step;
          end
        end
        default: ;
      endcase
    end
  end

  // Clear has priority over a coincident response handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lookups_q   <= '0;
      pred_hits_q <= '0;
    end else if (stat_clr) begin
      lookups_q   <= '0;
      pred_hits_q <= '0;
    end else if (handshake) begin
      if (lookups_q != CNT_MAX) lookups_q <= lookups_q + CNT_BITS'(1);
      if (pred_hit_q && (pred_hits_q != CNT_MAX)) begin
        pred_hits_q <= pred_hits_q + CNT_BITS'(1);
      end
    end
  end

  assign pred_index      = (state_q == IDLE) ? req_index : index_q;
  assign pred_actual_way = cur_way_q;
  assign tag_rd_index    = index_q;
  assign tag_rd_way      = cur_way_q;
  assign resp_valid      = (state_q == RESP);
  assign resp_hit        = hit_q;
  assign resp_way        = way_q;
  assign resp_pred_hit   = pred_hit_q;
  assign resp_probes     = probes_q;
  assign stat_lookups    = lookups_q;
  assign stat_pred_hits  = pred_hits_q;

endmodule
